// File: rtl/bus_pkg.sv
// Shared types, constants and address decode for the CPU external-bus responders.
package bus_pkg;

  typedef enum logic [1:0] {
    T1 = 2'd0,
    T2 = 2'd1,
    T3 = 2'd2,
    T4 = 2'd3
  } t_phase_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADR,
    S_DATA,
    S_COMMIT
  } phase_state_e;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_RD,
    ACC_WR
  } access_e;

  typedef struct packed {
    logic ram;
    logic ie;
  } hit_t;

  localparam logic [15:0] HRAM_BASE  = 16'hFF80;
  localparam int          HRAM_DEPTH = 127;
  localparam logic [15:0] IE_ADR     = 16'hFFFF;
  localparam logic [7:0]  OPEN_BUS   = 8'hFF;

  // IE wins if it ever overlaps the RAM window; ie_adr == 0 disables IE.
  function automatic hit_t decode_hit(input logic [15:0] adr, input logic [15:0] base,
                                      input int depth, input logic [15:0] ie_adr);
    hit_t h;
    int   a;
    int   b;
    a     = int'(adr);
    b     = int'(base);
    h.ie  = (ie_adr != 16'h0000) && (adr == ie_adr);
    h.ram = !h.ie && (a >= b) && (a < b + depth);
    return h;
  endfunction

endpackage

// File: rtl/hram_array.sv
// Synchronous single-port byte RAM; a read in the same cycle as a write returns the old data.
module hram_array #(
  parameter int DEPTH = 127,
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [IDX_W-1:0] addr,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);

  logic [7:0] mem [DEPTH];

  // NOTE: storage has no reset so it maps onto RAM macros; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/hram_bus_responder.sv
// High-RAM and IE responder: tracks the CPU T-state, serves reads/writes and flags protocol errors.
module hram_bus_responder
  import bus_pkg::*;
#(
  parameter logic [15:0] BASE   = HRAM_BASE,
  parameter int          DEPTH  = HRAM_DEPTH,
  parameter logic [15:0] IE_ADR = bus_pkg::IE_ADR
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [1:0]  t_phase,
  input  logic [15:0] cpu_adr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        sel,
  output logic [4:0]  ie,
  output logic        err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  phase_state_e     state_q, state_d;
  t_phase_e         ph;
  logic             phase_fault;
  hit_t             hit_now;
  access_e          acc_d, acc_q;
  logic             ie_sel_q;
  logic [IDX_W-1:0] idx_now, idx_q;
  logic             rd_edge, load_edge, commit_edge;
  logic             ram_en, ram_we;
  logic [7:0]       ram_q;

  assign ph      = t_phase_e'(t_phase);
  assign hit_now = decode_hit(cpu_adr, BASE, DEPTH, IE_ADR);
  assign idx_now = IDX_W'(cpu_adr - BASE);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    acc_d = ACC_NONE;
    if ((hit_now.ram || hit_now.ie) && (cpu_rd ^ cpu_wr))
      acc_d = cpu_rd ? ACC_RD : ACC_WR;
  end

  // T1 always starts a new M-cycle; a T1 arriving mid-cycle is still an ordering error.
  always_comb begin
    state_d     = state_q;
    phase_fault = 1'b0;
    if (ph == T1) begin
      state_d     = S_ADR;
      phase_fault = (state_q != S_IDLE);
    end else begin
      unique case (state_q)
        S_IDLE:   state_d = S_IDLE;
        S_ADR:    begin state_d = (ph == T2) ? S_DATA   : S_IDLE; phase_fault = (ph != T2); end
        S_DATA:   begin state_d = (ph == T3) ? S_COMMIT : S_IDLE; phase_fault = (ph != T3); end
        S_COMMIT: begin state_d = S_IDLE;                          phase_fault = (ph != T4); end
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  assign rd_edge     = (state_q == S_ADR)    && (ph == T2) && (acc_q == ACC_RD);
  assign load_edge   = (state_q == S_DATA)   && (ph == T3) && (acc_q == ACC_RD);
  assign commit_edge = (state_q == S_COMMIT) && (ph == T4) && (acc_q == ACC_WR);
  assign ram_en      = (rd_edge || commit_edge) && !ie_sel_q;
  assign ram_we      = commit_edge && !ie_sel_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      acc_q    <= ACC_NONE;
      ie_sel_q <= 1'b0;
      idx_q    <= '0;
      sel      <= 1'b0;
      cpu_din  <= OPEN_BUS;
      ie       <= '0;
      err      <= 1'b0;
    end else begin
      if (phase_fault) err <= 1'b1;
      if (ph == T1) begin
        acc_q    <= acc_d;
        ie_sel_q <= hit_now.ie;
        idx_q    <= idx_now;
        sel      <= 1'b0;
        cpu_din  <= OPEN_BUS;
        if (cpu_rd && cpu_wr) err <= 1'b1;
      end else if (phase_fault) begin
        acc_q   <= ACC_NONE;
        sel     <= 1'b0;
        cpu_din <= OPEN_BUS;
      end else begin
        if (rd_edge)   sel     <= 1'b1;
        if (load_edge) cpu_din <= ie_sel_q ? {3'b111, ie} : ram_q;
        if (commit_edge && ie_sel_q) ie <= cpu_dout[4:0];
      end
    end
  end

  hram_array #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (idx_q),
    .wdata(cpu_dout),
    .rdata(ram_q)
  );

endmodule

// File: tb/tb_hram_bus_responder.sv
// Directed bench for hram_bus_responder: vector table of whole M-cycles plus multi-cycle corner sequences.
module tb_hram_bus_responder;

  logic        clk;
  logic        nreset;
  logic [1:0]  t_phase;
  logic [15:0] cpu_adr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        sel;
  logic [4:0]  ie;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [15:0] adr;
    logic        rd;
    logic        wr;
    logic [7:0]  dout;
    logic        exp_sel;
    logic [7:0]  exp_din;
    logic [4:0]  exp_ie;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  hram_bus_responder dut (
    .clk     (clk),
    .nreset  (nreset),
    .t_phase (t_phase),
    .cpu_adr (cpu_adr),
    .cpu_rd  (cpu_rd),
    .cpu_wr  (cpu_wr),
    .cpu_dout(cpu_dout),
    .cpu_din (cpu_din),
    .sel     (sel),
    .ie      (ie),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one T-state on the falling edge, then return just after the rising edge that samples it.
  task automatic drive_phase(input logic [1:0] p, input logic [15:0] a, input logic r,
                             input logic w, input logic [7:0] d);
    @(negedge clk);
    t_phase  = p;
    cpu_adr  = a;
    cpu_rd   = r;
    cpu_wr   = w;
    cpu_dout = d;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    drive_phase(2'd0, v.adr, v.rd, v.wr, v.dout);
    check({tag, " sel_t1"}, 16'(sel), 16'h0);
    drive_phase(2'd1, v.adr, v.rd, v.wr, v.dout);
    check({tag, " sel_t2"}, 16'(sel), 16'(v.exp_sel));
    drive_phase(2'd2, v.adr, v.rd, v.wr, v.dout);
    check({tag, " din_t3"}, 16'(cpu_din), 16'(v.exp_din));
    drive_phase(2'd3, v.adr, v.rd, v.wr, v.dout);
    check({tag, " sel_t4"}, 16'(sel), 16'(v.exp_sel));
    check({tag, " din_t4"}, 16'(cpu_din), 16'(v.exp_din));
    check({tag, " ie"}, 16'(ie), 16'(v.exp_ie));
    check({tag, " err"}, 16'(err), 16'(v.exp_err));
  endtask

  function automatic vec_t mk(input logic [15:0] adr, input logic rd, input logic wr,
                              input logic [7:0] dout, input logic es, input logic [7:0] ed,
                              input logic [4:0] ei, input logic ee);
    vec_t v;
    v.adr = adr; v.rd = rd; v.wr = wr; v.dout = dout;
    v.exp_sel = es; v.exp_din = ed; v.exp_ie = ei; v.exp_err = ee;
    return v;
  endfunction

  initial begin
    //            adr       rd wr dout    sel din     ie      err
    vecs[0]  = mk(16'hFF80, 1, 0, 8'h00, 0, 8'hFF, 5'h00, 0);  // read of unwritten-irrelevant: see below
    vecs[0]  = mk(16'hFF80, 0, 1, 8'h5A, 0, 8'hFF, 5'h00, 0);
    vecs[1]  = mk(16'hFF80, 1, 0, 8'h00, 1, 8'h5A, 5'h00, 0);
    vecs[2]  = mk(16'hFFFE, 0, 1, 8'h3C, 0, 8'hFF, 5'h00, 0);
    vecs[3]  = mk(16'hFFFE, 1, 0, 8'h00, 1, 8'h3C, 5'h00, 0);
    vecs[4]  = mk(16'hFF7F, 1, 0, 8'h00, 0, 8'hFF, 5'h00, 0);
    vecs[5]  = mk(16'hFFFF, 0, 1, 8'hFF, 0, 8'hFF, 5'h1F, 0);
    vecs[6]  = mk(16'hFFFF, 1, 0, 8'h00, 1, 8'hFF, 5'h1F, 0);
    vecs[7]  = mk(16'hFFFF, 0, 1, 8'h05, 0, 8'hFF, 5'h05, 0);
    vecs[8]  = mk(16'hFFFF, 1, 0, 8'h00, 1, 8'hE5, 5'h05, 0);
    vecs[9]  = mk(16'hFF81, 0, 1, 8'h11, 0, 8'hFF, 5'h05, 0);
    vecs[10] = mk(16'hFF82, 0, 1, 8'h22, 0, 8'hFF, 5'h05, 0);
    vecs[11] = mk(16'hFF90, 0, 1, 8'h44, 0, 8'hFF, 5'h05, 0);
    vecs[12] = mk(16'hFF7F, 0, 1, 8'h99, 0, 8'hFF, 5'h05, 0);
    vecs[13] = mk(16'hFF82, 1, 0, 8'h00, 1, 8'h22, 5'h05, 0);
    vecs[14] = mk(16'hFF80, 1, 0, 8'h00, 1, 8'h5A, 5'h05, 0);
    vecs[15] = mk(16'hFF80, 0, 0, 8'h00, 0, 8'hFF, 5'h05, 0);
    vecs[16] = mk(16'h0000, 1, 0, 8'h00, 0, 8'hFF, 5'h05, 0);

    nreset = 1'b0; t_phase = 2'd0; cpu_adr = '0; cpu_rd = 0; cpu_wr = 0; cpu_dout = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset sel", 16'(sel), 16'h0);
    check("reset din", 16'(cpu_din), 16'h00FF);
    check("reset ie", 16'(ie), 16'h0);
    check("reset err", 16'(err), 16'h0);
    @(negedge clk);
    t_phase = 2'd3;
    nreset  = 1'b1;

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Address and strobe changes after T1 are ignored.
    drive_phase(2'd0, 16'hFF81, 1, 0, 8'h00);
    drive_phase(2'd1, 16'hFF81, 1, 0, 8'h00);
    drive_phase(2'd2, 16'hFF82, 0, 1, 8'hEE);
    check("late_adr din_t3", 16'(cpu_din), 16'h0011);
    drive_phase(2'd3, 16'hFF82, 0, 1, 8'hEE);
    check("late_adr din_t4", 16'(cpu_din), 16'h0011);
    check("late_adr sel_t4", 16'(sel), 16'h1);
    run_vec(mk(16'hFF82, 1, 0, 8'h00, 1, 8'h22, 5'h05, 0), "late_adr ram");

    // Read and write together: error, no access.
    drive_phase(2'd0, 16'hFF80, 1, 1, 8'hAA);
    check("rdwr err", 16'(err), 16'h1);
    drive_phase(2'd1, 16'hFF80, 1, 1, 8'hAA);
    check("rdwr sel_t2", 16'(sel), 16'h0);
    drive_phase(2'd2, 16'hFF80, 1, 1, 8'hAA);
    drive_phase(2'd3, 16'hFF80, 1, 1, 8'hAA);
    check("rdwr din_t4", 16'(cpu_din), 16'h00FF);
    run_vec(mk(16'hFF80, 1, 0, 8'h00, 1, 8'h5A, 5'h05, 1), "rdwr ram");

    // Reset during T3 of a write drops the write and clears outputs at once.
    drive_phase(2'd0, 16'hFF90, 0, 1, 8'h77);
    drive_phase(2'd1, 16'hFF90, 0, 1, 8'h77);
    drive_phase(2'd2, 16'hFF90, 0, 1, 8'h77);
    #2;
    nreset = 1'b0;
    #1;
    check("midrst sel", 16'(sel), 16'h0);
    check("midrst din", 16'(cpu_din), 16'h00FF);
    check("midrst ie", 16'(ie), 16'h0);
    check("midrst err", 16'(err), 16'h0);
    @(negedge clk);
    t_phase = 2'd3; cpu_wr = 0;
    @(negedge clk);
    nreset = 1'b1;
    run_vec(mk(16'hFF90, 1, 0, 8'h00, 1, 8'h44, 5'h00, 0), "midrst ram");
    run_vec(mk(16'hFFFF, 1, 0, 8'h00, 1, 8'hE0, 5'h00, 0), "midrst ie_rd");

    // Skipped T3: error, no write; the next clean M-cycles are served.
    drive_phase(2'd0, 16'hFF81, 0, 1, 8'h66);
    drive_phase(2'd1, 16'hFF81, 0, 1, 8'h66);
    drive_phase(2'd3, 16'hFF81, 0, 1, 8'h66);
    check("skip err", 16'(err), 16'h1);
    run_vec(mk(16'hFF81, 1, 0, 8'h00, 1, 8'h11, 5'h00, 1), "skip nowr");
    run_vec(mk(16'hFF81, 0, 1, 8'h66, 0, 8'hFF, 5'h00, 1), "skip wr");
    run_vec(mk(16'hFF81, 1, 0, 8'h00, 1, 8'h66, 5'h00, 1), "skip rd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
